imm_gen_pipe: RTL

Registered, flow-controlled immediate generator: the successor to the combinational immediate generator. It decodes the instruction format from the opcode field itself, with no separate opcode input. It produces one sign-extended immediate of parametrised width plus a format code and an illegal flag. Results pass through a 2-entry output buffer with valid/ready handshakes, so the block can sit between fetch and decode in the pipelined core.

---
 rtl/imm_gen_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, flow-controlled immediate generator.
// Decodes the instruction format from inst[6:0], assembles a sign-extended
// immediate, and queues {imm, fmt, illegal} in a 2-entry output FIFO.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   flush          synchronous clear of buffered results (beats push/pop)
//   in_valid/in_ready/inst            instruction input handshake
//   out_valid/out_ready               result output handshake
//   out_imm/out_fmt/out_illegal       head entry (all zero when empty)
//
// out_fmt encoding: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5
  } fmt_e;

  localparam bit IsRv64 = (XLEN == 64);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;

  // Every legal opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    dec_fmt = FmtNone;
    dec_ill = 1'b0;
    case (inst[6:0])
      7'b0110011: dec_fmt = FmtNone;
      7'b0111011: dec_ill = !IsRv64;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: dec_fmt = FmtI;
      7'b0011011: begin
        if (IsRv64) dec_fmt = FmtI;
        else        dec_ill = 1'b1;
      end
      7'b0100011: dec_fmt = FmtS;
      7'b1100011: dec_fmt = FmtB;
      7'b0110111, 7'b0010111: dec_fmt = FmtU;
      7'b1101111: dec_fmt = FmtJ;
      default:    dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FmtI: imm32 = {{20{inst[31]}}, inst[31:20]};
      FmtS: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FmtB: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU: imm32 = {inst[31:12], 12'b0};
      FmtJ: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen to XLEN by replicating bit 31 (sign is always inst[31]).
  always_comb begin
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_q [2];
  logic [2:0]      fmt_q [2];
  logic            ill_q [2];

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);

  // Flush suppresses both handshakes so the offered instruction is dropped.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_ptr_q] <= dec_imm;
      fmt_q[wr_ptr_q] <= dec_fmt;
      ill_q[wr_ptr_q] <= dec_ill;
    end
  end

  always_comb begin
    out_imm     = '0;
    out_fmt     = 3'd0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_imm     = imm_q[rd_ptr_q];
      out_fmt     = fmt_q[rd_ptr_q];
      out_illegal = ill_q[rd_ptr_q];
    end
  end

endmodule
